pkt_desc_fifo: RTL
==================

# pkt_desc_fifo

Show-ahead FIFO for packet descriptors (`pkt_desc_type`) built around the team's 1R1W block-RAM descriptor store. It owns both write and read pointers. It hides the RAM's one-cycle registered read latency behind a prefetch/output stage, so consumers see a valid/ready stream with the head descriptor already on `dout`. It sits between the descriptor producer (enqueue side) and the scheduler/queue logic that pops descriptors.

## Interface
- `DEPTH_NBITS`, default 4: log2 of RAM depth.
- `DEPTH`, default `1<<DEPTH_NBITS`: total descriptor capacity, including entries held in the output stage.
- `clk` input 1: single clock; all state on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `push` input 1: enqueue `din` this cycle.
- `din` input `pkt_desc_type`: descriptor to enqueue; width `PKT_DESC_NBITS`.
- `full` output 1: `count == DEPTH`.
- `dout_valid` output 1: `dout` holds the head descriptor.
- `dout` output `pkt_desc_type`: head descriptor; stable while `dout_valid && !dout_ready`.
- `dout_ready` input 1: consumer accepts `dout` when `dout_valid` is high.
- `empty` output 1: `count == 0`.
- `count` output `DEPTH_NBITS+1`: number of stored descriptors, RAM plus output stage.
- `overflow` output 1: sticky; set on a push while full.

## Operation
- **Storage.** The RAM is an internal instance with 1 read and 1 write port. It has registered read data, one cycle after `raddr`. Descriptor field packing is fixed: `{q_id, conn_id, conn_group_id, port_queue_id, src_port, dst_port, len, idx}`, MSB first.
- **Write.** An accepted push (`push && !full`) writes `mem[wptr]`, then `wptr <= wptr+1`. Pointers are `DEPTH_NBITS` wide and wrap naturally from `DEPTH-1` to 0.
- **Rejected push.** A push with `full` high is dropped. `overflow` is set and `count` is unchanged. A pop in the same cycle does not rescue the push, because `full` is registered-count based.
- **Prefetch.** A RAM read is issued whenever `rptr != wptr` (RAM holds unread data) and the output pipeline has room. Room means the output register plus one in-flight read slot is not committed. Then `rptr <= rptr+1`.
- **Read-during-write.** The RAM never reads an address in the same cycle it is written. A descriptor written at edge E becomes readable from cycle E+1.
- **Output stage.** It is a 2-entry skid: the RAM output register plus one holding register. This guarantees no read data is lost when `dout_ready` drops while a read is in flight.
- **Pop.** `dout_valid && dout_ready` consumes the head. The next entry, if present, appears on `dout` in the following cycle with no bubble.
- **Count update.** `count` increments on an accepted push and decrements on a pop. A simultaneous accepted push and pop leaves `count` unchanged.
- **Flags.** `empty` and `full` derive from `count`.
- **Invalid pop.** `dout_ready` while `!dout_valid` is ignored.
- **Reset.** `rstn` low resets, mid-operation included: `wptr=rptr=0`, `count=0`, `full=0`, `empty=1`, `dout_valid=0`, `dout=0`, `overflow=0`, and the in-flight read is discarded. RAM contents are not cleared.

## Timing
- **Empty-FIFO latency.** Push accepted at edge E0 gives `count=1` and `empty=0` after E0. The read is issued in cycle E0→E1 and data is registered at E1. `dout_valid` goes high after E1, 2 edges after the push.
- **Sustained throughput.** 1 push and 1 pop per cycle, with no bubbles once `dout_valid` is high.
- **Back-pressure.** With `dout_ready` low, `dout` and `dout_valid` hold. At most one additional prefetched entry is parked in the skid register.
- **Full timing.** `full` asserts the cycle after the push that brings `count` to `DEPTH`. It deasserts the cycle after a pop from full.
- **Overflow timing.** `overflow` rises the edge after the rejected push and stays high until reset.

## Test plan
- **Empty latency.** After reset, push descriptor `idx=5` at E0 with `dout_ready=1` → `dout_valid=1` with `dout.idx=5` after E1; it pops at E2, then `empty=1` and `count=0`.
- **Fill and drain.** Push 16 descriptors `idx=0..15` (`DEPTH_NBITS=4`) with `dout_ready=0` → `full=1` and `count=16`. A 17th push sets `overflow=1` and is dropped. Draining then returns exactly `idx=0..15` in order.
- **Wrap-around streaming.** Continuous push and pop of 40 descriptors with `dout_ready=1` → in-order output, `count` never exceeds 2, and pointers wrap twice with no bubble after the first valid.
- **Random back-pressure.** Toggle `dout_ready` pseudo-randomly (50%) while pushing 100 descriptors → no loss or duplication, and `dout` stays stable whenever `dout_valid && !dout_ready`.
- **Simultaneous push and pop at full.** At `count=16`, `push=1` and `dout_ready=1` in the same cycle → push dropped, `overflow=1`, `count=15`.
- **Reset mid-stream.** Assert `rstn=0` with `count=7` and a read in flight → all outputs return to reset values immediately. After release, a new push appears 2 edges later with the correct content.

Source files
------------

// File: rtl/pkt_desc_fifo.sv
// pkt_desc_fifo: show-ahead FIFO for packet descriptors.
// A 1R1W RAM with registered read data holds the bulk of the queue. A
// two-entry output stage (the RAM read register plus one skid register)
// hides the read latency. The head descriptor therefore sits on dout
// whenever dout_valid is high.

package pkt_desc_pkg;
  localparam int Q_ID_NBITS          = 6;
  localparam int CONN_ID_NBITS       = 10;
  localparam int CONN_GROUP_ID_NBITS = 4;
  localparam int PORT_QUEUE_ID_NBITS = 3;
  localparam int PORT_NBITS          = 4;
  localparam int LEN_NBITS           = 14;
  localparam int IDX_NBITS           = 16;

  // Field order is MSB first and fixed; the RAM stores this packing verbatim.
  typedef struct packed {
    logic [Q_ID_NBITS-1:0]          q_id;
    logic [CONN_ID_NBITS-1:0]       conn_id;
    logic [CONN_GROUP_ID_NBITS-1:0] conn_group_id;
    logic [PORT_QUEUE_ID_NBITS-1:0] port_queue_id;
    logic [PORT_NBITS-1:0]          src_port;
    logic [PORT_NBITS-1:0]          dst_port;
    logic [LEN_NBITS-1:0]           len;
    logic [IDX_NBITS-1:0]           idx;
  } pkt_desc_type;

  localparam int PKT_DESC_NBITS = $bits(pkt_desc_type);
endpackage

// 1R1W descriptor store. Read data is registered one cycle after raddr.
// The storage array has no reset. The read register does reset, so the
// FIFO's dout is 0 coming out of reset.
module pkt_desc_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is issued
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

module pkt_desc_fifo
  import pkt_desc_pkg::*;
#(
  parameter int DEPTH_NBITS = 4,
  parameter int DEPTH       = 1 << DEPTH_NBITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  pkt_desc_type         din,
  output logic                 full,
  output logic                 dout_valid,
  output pkt_desc_type         dout,
  input  logic                 dout_ready,
  output logic                 empty,
  output logic [DEPTH_NBITS:0] count,
  output logic                 overflow
);
  localparam logic [DEPTH_NBITS:0]   CNT_FULL = DEPTH[DEPTH_NBITS:0];
  localparam logic [DEPTH_NBITS:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_NBITS-1:0] PTR_ONE  = 1;

  logic [DEPTH_NBITS-1:0] wptr, rptr;
  logic                   wr_en, rd_en, pop;
  logic                   rq_vld;   // RAM read register holds a live entry
  logic                   sk_vld;   // skid register holds a live entry
  pkt_desc_type           rq_data, sk;

  // A push while full is dropped. full is derived from the registered
  // count, so a pop in the same cycle cannot make room for the push.
  assign wr_en = push && !full;
  assign pop   = dout_valid && dout_ready;

  // The skid register only fills when the read register is also live, so
  // sk_vld alone means the stage holds two entries. A read may be issued
  // when the stage will have a free slot after this cycle's pop. Reading
  // only when rptr != wptr also keeps the read address off the slot being
  // written this cycle.
  assign rd_en = (rptr != wptr) && (!sk_vld || pop);

  // The skid register holds the older entry, so it is the head when live
  assign dout       = sk_vld ? sk : rq_data;
  assign dout_valid = sk_vld | rq_vld;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  pkt_desc_ram #(
    .AW (DEPTH_NBITS),
    .DW (PKT_DESC_NBITS)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_en),
    .raddr (rptr),
    .rdata (rq_data)
  );

  // Write and read pointers; both wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
    end
  end

  // Output stage occupancy. A new read overwrites the read register at the
  // edge, so a surviving entry there first moves to the skid register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rq_vld <= 1'b0;
      sk_vld <= 1'b0;
      sk     <= '0;
    end else if (rd_en) begin
      rq_vld <= 1'b1;
      if (rq_vld && !(pop && !sk_vld)) begin
        sk     <= rq_data;
        sk_vld <= 1'b1;
      end else begin
        sk_vld <= 1'b0;
      end
    end else if (pop) begin
      if (sk_vld) sk_vld <= 1'b0;
      else        rq_vld <= 1'b0;
    end
  end

  // Occupancy counts everything stored: RAM entries plus output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; only reset clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             overflow <= 1'b0;
    else if (push && full) overflow <= 1'b1;
  end
endmodule
